weight_load_scheduler: RTL

Sequences per-layer weight loading for the 3x3 MLP datapath. Reads 9 signed 8-bit weights per layer from a synchronous weight SRAM and pushes them column by column into the dual weight FIFO. It kicks off the MLP for layer 0, then serves each later layer's weight request with a `weights_ready` handshake. It sits between the weight SRAM and the MLP top-level controller, and owns every write-side signal of the weight FIFO.

---
 rtl/mlp_pkg.sv | 18 +
 rtl/wls_addr_gen.sv | 62 ++++++
 rtl/weight_load_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the 3x3 MLP weight path.
package mlp_pkg;

  localparam int unsigned ARRAY_DIM         = 3;
  localparam int unsigned WEIGHTS_PER_LAYER = ARRAY_DIM * ARRAY_DIM;

  typedef logic signed [7:0] weight_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_FLUSH,
    S_KICK,
    S_READY
  } wls_state_t;

endpackage

// File: rtl/wls_addr_gen.sv
// Weight index counter, per-layer SRAM address adder and push column decode.
module wls_addr_gen
  import mlp_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DIM    = 3,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              adv,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [2:0]        layer_idx,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] rd_addr_next,
  output logic [DIM-1:0]    col_sel
);

  localparam int unsigned LAYER_WORDS = DIM * DIM;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  idx_dly_q;
  logic [ADDR_W-1:0] layer_off;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (adv) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Address is formed from the next index so the registered read address
  // lines up with the cycle in which idx_q holds that index.
  always_comb begin
    layer_off    = ADDR_W'(layer_idx) * ADDR_W'(LAYER_WORDS);
    rd_addr_next = base_addr + layer_off + ADDR_W'(idx_d);
  end

  // idx_dly_q tracks the index whose read data is arriving this cycle.
  always_comb begin
    col_sel = '0;
    for (int unsigned c = 0; c < DIM; c++) begin
      col_sel[c] = ((32'(idx_dly_q) / DIM) == c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      idx_dly_q <= '0;
    end else begin
      idx_q     <= idx_d;
      idx_dly_q <= idx_q;
    end
  end

  assign idx = idx_q;

endmodule

// File: rtl/weight_load_scheduler.sv
// Per-layer weight loader: SRAM -> dual weight FIFO, with MLP handshakes.
// Optional running XOR of pushed bytes under WEIGHT_SCHED_CHECKSUM_EN.
module weight_load_scheduler
  import mlp_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 2,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned ARRAY_DIM  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              layer_req,
  input  logic              layer_ack,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              wf_reset,
  output logic              wf_push_col0,
  output logic              wf_push_col1,
  output logic              wf_push_col2,
  output logic [7:0]        wf_data_in,
  output logic              start_mlp,
  output logic              weights_ready,
  output logic              busy,
  output logic [2:0]        layer_idx,
  output logic              done,
  output logic              err,
  output logic [7:0]        checksum
);

  localparam int unsigned LAYER_WORDS = ARRAY_DIM * ARRAY_DIM;
  localparam int unsigned IDX_W       = $clog2(LAYER_WORDS);
  localparam logic [2:0]  LAST_LAYER  = 3'(NUM_LAYERS - 1);

  wls_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        layer_q, layer_d;
  logic              wf_reset_q, wf_reset_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              push_q, push_d;
  logic              start_q, start_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              clr, adv;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] rd_addr_next;
  logic [ARRAY_DIM-1:0] col_sel;
  weight_t           push_byte;

  wls_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM    (ARRAY_DIM),
    .IDX_W  (IDX_W)
  ) u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .adv          (adv),
    .base_addr    (base_q),
    .layer_idx    (layer_q),
    .idx          (idx),
    .rd_addr_next (rd_addr_next),
    .col_sel      (col_sel)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    layer_d    = layer_q;
    wf_reset_d = 1'b0;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    push_d     = rd_en_q;
    start_d    = 1'b0;
    wr_d       = wr_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    clr        = 1'b0;
    adv        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          base_d     = base_addr;
          layer_d    = '0;
          wf_reset_d = 1'b1;
          state_d    = S_CLEAR;
        end
        err_d = layer_req;
      end
      S_CLEAR: begin
        clr       = 1'b1;
        rd_en_d   = 1'b1;
        rd_addr_d = rd_addr_next;
        state_d   = S_FETCH;
      end
      S_FETCH: begin
        if (idx == IDX_W'(LAYER_WORDS - 1)) begin
          state_d = S_FLUSH;
        end else begin
          adv       = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_next;
        end
      end
      S_FLUSH: begin
        if (layer_q == '0) begin
          start_d = 1'b1;
          state_d = S_KICK;
        end else begin
          wr_d    = 1'b1;
          state_d = S_READY;
        end
      end
      S_KICK: begin
        if (NUM_LAYERS == 1) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        // Ack is resolved before a same-cycle request.
        if (layer_ack && wr_q) begin
          wr_d = 1'b0;
          if (layer_q == LAST_LAYER) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (layer_req) begin
          if (layer_q == LAST_LAYER) begin
            err_d = 1'b1;
          end else begin
            layer_d    = layer_q + 3'd1;
            wr_d       = 1'b0;
            wf_reset_d = 1'b1;
            state_d    = S_CLEAR;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && run) begin
      err_d = 1'b1;
    end
    if (state_q != S_IDLE && state_q != S_READY && layer_req) begin
      err_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      layer_q    <= '0;
      wf_reset_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      push_q     <= 1'b0;
      start_q    <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      layer_q    <= layer_d;
      wf_reset_q <= wf_reset_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      push_q     <= push_d;
      start_q    <= start_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign push_byte     = push_q ? weight_t'(mem_rd_data) : '0;
  assign wf_data_in    = push_byte;
  assign wf_push_col0  = push_q & col_sel[0];
  assign wf_push_col1  = push_q & col_sel[1];
  assign wf_push_col2  = push_q & col_sel[2];
  assign mem_rd_en     = rd_en_q;
  assign mem_rd_addr   = rd_addr_q;
  assign wf_reset      = wf_reset_q;
  assign start_mlp     = start_q;
  assign weights_ready = wr_q;
  assign busy          = busy_q;
  assign layer_idx     = layer_q;
  assign done          = done_q;
  assign err           = err_q;

`ifdef WEIGHT_SCHED_CHECKSUM_EN
  logic [7:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == S_CLEAR && layer_q == '0) begin
      checksum_d = '0;
    end else if (push_q) begin
      checksum_d = checksum_q ^ wf_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

endmodule
